// File: rtl/jtframe_ba_pkg.sv
// -----------------------------------------------------------------------------
// jtframe_ba_pkg
// Shared types and constants for the BRAM-backed JTFRAME bank responder.
//   ba_state_t : responder FSM states (ST_REF only with JTFRAME_BA_REFRESH_EN)
//   ba_req_t   : latched request (address, type, write data, byte mask)
//   *_MIN/_MAX : legal bounds for the LATENCY and BURST parameters
// Optional feature macro: JTFRAME_BA_REFRESH_EN
// -----------------------------------------------------------------------------
package jtframe_ba_pkg;

  localparam int DW        = 16;  // data word width
  localparam int AW_MAX    = 24;  // widest address any instance may use
  localparam int LAT_MIN   = 1;
  localparam int LAT_MAX   = 8;
  localparam int BURST_MIN = 1;
  localparam int BURST_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT,
    ST_DATA,
    ST_WEND
`ifdef JTFRAME_BA_REFRESH_EN
    , ST_REF
`endif
  } ba_state_t;

  typedef struct packed {
    logic [AW_MAX-1:0] addr;
    logic              wr;
    logic [DW-1:0]     din;
    logic [1:0]        mask;  // 1 = keep that byte lane
  } ba_req_t;

  // Byte-enables are the inverse of the initiator's "leave unwritten" mask.
  function automatic logic [1:0] lane_en(input logic [1:0] mask);
    return ~mask;
  endfunction

endpackage

// File: rtl/jtframe_ba_ram.sv
// -----------------------------------------------------------------------------
// jtframe_ba_ram
// Single-port 2^AW x 16 RAM, two byte-enables, registered read output.
//   clk     : clock
//   i_rst   : synchronous active-high clear of the output register only
//   i_addr  : shared read/write word address
//   i_we    : write strobe, i_be selects byte lanes ([1]=upper, [0]=lower)
//   i_din   : write data
//   i_re    : read enable; o_dout holds its value while low
//   o_dout  : registered read data
// -----------------------------------------------------------------------------
module jtframe_ba_ram
  import jtframe_ba_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [1:0]    i_be,
  input  logic [DW-1:0] i_din,
  input  logic          i_re,
  output logic [DW-1:0] o_dout
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // output register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_be[0]) r_mem[i_addr][7:0]  <= i_din[7:0];
      if (i_be[1]) r_mem[i_addr][15:8] <= i_din[15:8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_rst)     r_dout <= '0;
    else if (i_re) r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/jtframe_ba_responder.sv
// -----------------------------------------------------------------------------
// jtframe_ba_responder
// Responder end of the JTFRAME SDRAM bank request protocol, serving one bank
// from on-chip RAM with SDRAM-like latency and burst timing.
//   clk, rst          : clock, synchronous active-high reset
//   ba_addr           : word address, latched on acceptance
//   ba_rd / ba_wr     : read / write requests, held until ba_ack
//   ba_din, ba_din_m  : write data and byte mask (1 = lane unwritten)
//   ba_ack            : one-cycle acceptance pulse
//   ba_dst            : first read word
//   ba_dok            : dout holds a valid read word
//   ba_rdy            : last cycle of every transaction
//   dout              : read data, holds between bursts
//   busy              : FSM not in IDLE
// Optional feature macro: JTFRAME_BA_REFRESH_EN (periodic refresh blackout
// of REF_LEN cycles every REF_PERIOD cycles).
// -----------------------------------------------------------------------------
module jtframe_ba_responder
  import jtframe_ba_pkg::*;
#(
  parameter int AW         = 10,
  parameter int BURST      = 2,
  parameter int LATENCY    = 2,
  parameter int REF_PERIOD = 384,
  parameter int REF_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ba_addr,
  input  logic          ba_rd,
  input  logic          ba_wr,
  input  logic [DW-1:0] ba_din,
  input  logic [1:0]    ba_din_m,
  output logic          ba_ack,
  output logic          ba_dst,
  output logic          ba_dok,
  output logic          ba_rdy,
  output logic [DW-1:0] dout,
  output logic          busy
);

  localparam int CW = 16;  // phase counter, also covers REF_LEN

  ba_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  ba_req_t           r_req;
  logic              w_accept;
  ba_state_t         w_after_wait;
  logic              w_ram_we, w_ram_re;
  logic [AW_MAX-1:0] w_beat_off;
  logic [AW-1:0]     w_ram_addr;

`ifdef JTFRAME_BA_REFRESH_EN
  localparam int PW = $clog2(REF_PERIOD + 1);
  logic [PW-1:0] r_ref_cnt;
  logic          r_ref_pend;
  logic          w_ref_tick, w_ref_due, w_ref_start;

  assign w_ref_tick = (r_ref_cnt == PW'(REF_PERIOD - 1));
  assign w_ref_due  = r_ref_pend | w_ref_tick;

  // A tick that lands mid-transaction is remembered until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      r_ref_cnt  <= w_ref_tick ? '0 : r_ref_cnt + PW'(1);
      r_ref_pend <= (r_ref_pend | w_ref_tick) & ~w_ref_start;
    end
  end
`endif

  assign w_after_wait = r_req.wr ? ST_WEND : ST_DATA;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
`ifdef JTFRAME_BA_REFRESH_EN
    w_ref_start = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef JTFRAME_BA_REFRESH_EN
        if (w_ref_due) begin
          w_state_nxt = ST_REF;
          w_ref_start = 1'b1;
        end else
`endif
        if (ba_rd | ba_wr) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = (LATENCY == 1) ? w_after_wait : ST_WAIT;
      ST_WAIT: if (r_cnt == CW'(LATENCY - 2)) w_state_nxt = w_after_wait;
      ST_DATA: if (r_cnt == CW'(BURST - 1))   w_state_nxt = ST_IDLE;
      ST_WEND: w_state_nxt = ST_IDLE;
`ifdef JTFRAME_BA_REFRESH_EN
      // The last blackout cycle doubles as an acceptance slot, so a waiting
      // request sees ba_ack in the first cycle after REF.
      ST_REF: begin
        if (r_cnt == CW'(REF_LEN - 1)) begin
          if (ba_rd | ba_wr) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ACK;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Counter measures time spent in the current state.
      r_cnt   <= (w_state_nxt == r_state) ? r_cnt + CW'(1) : '0;
      if (w_accept) begin
        r_req.addr <= AW_MAX'(ba_addr);
        r_req.wr   <= ba_wr;  // write wins when both are high
        r_req.din  <= ba_din;
        r_req.mask <= ba_din_m;
      end
    end
  end

  // The RAM output is registered, so each word is addressed one cycle before
  // the DATA cycle that shows it: offset 0 from the cycle before DATA, then
  // beat+1 while in DATA. Truncation to AW bits wraps the burst at the top.
  assign w_beat_off = (r_state == ST_DATA) ? AW_MAX'(r_cnt) + AW_MAX'(1) : '0;
  assign w_ram_addr = AW'(r_req.addr + w_beat_off);
  assign w_ram_re   = (w_state_nxt == ST_DATA);
  assign w_ram_we   = (r_state == ST_ACK) && r_req.wr;

  jtframe_ba_ram #(.AW(AW)) u_ram (
    .clk    (clk),
    .i_rst  (rst),
    .i_addr (w_ram_addr),
    .i_we   (w_ram_we),
    .i_be   (lane_en(r_req.mask)),
    .i_din  (r_req.din),
    .i_re   (w_ram_re),
    .o_dout (dout)
  );

  assign ba_ack = (r_state == ST_ACK);
  assign ba_dok = (r_state == ST_DATA);
  assign ba_dst = ba_dok && (r_cnt == '0);
  assign ba_rdy = (ba_dok && (r_cnt == CW'(BURST - 1))) || (r_state == ST_WEND);
  assign busy   = (r_state != ST_IDLE);

endmodule
